// File: rtl/wb_commit.sv
// Writeback commit: buffers ALU/LSU results in a FIFO, drives the register-file
// write port one entry per cycle and keeps a busy scoreboard for decode stalls.
// Optional feature macro: WB_FWD_EN (lookup of buffered results for forwarding).
// Ports:
//   i_clk, i_rst_n             clock, synchronous active-low reset
//   i_alu_* / o_alu_ready      ALU result handshake (lower priority)
//   i_lsu_* / o_lsu_ready      load result handshake (higher priority)
//   i_issue_valid/i_issue_rd   decode marks a destination as pending
//   i_wb_hold                  suppress writes while the port is borrowed
//   o_rd_addr/o_rd_data        FIFO head; o_write_en pops it
//   o_busy, o_full             scoreboard and FIFO-full flag
//   i_rsN_addr/o_fwdN_*        forwarding lookup (zero unless WB_FWD_EN)
module wb_commit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    output logic            o_alu_ready,
    input  logic            i_lsu_valid,
    input  logic [4:0]      i_lsu_rd,
    input  logic [XLEN-1:0] i_lsu_data,
    output logic            o_lsu_ready,
    input  logic            i_issue_valid,
    input  logic [4:0]      i_issue_rd,
    input  logic            i_wb_hold,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_write_en,
    output logic [31:0]     o_busy,
    output logic            o_full,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic            o_fwd1_hit,
    output logic [XLEN-1:0] o_fwd1_data,
    output logic            o_fwd2_hit,
    output logic [XLEN-1:0] o_fwd2_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     busy_q;

    logic            full;
    logic            empty;
    logic            lsu_acc;
    logic            alu_acc;
    logic [4:0]      push_rd;
    logic [XLEN-1:0] push_data;
    logic            push;
    logic            pop;
    logic [31:0]     busy_set;
    logic [31:0]     busy_clr;
    logic [31:0]     busy_nxt;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign o_lsu_ready = ~full;
    assign o_alu_ready = ~full & ~i_lsu_valid;

    assign lsu_acc = i_lsu_valid & ~full;
    assign alu_acc = i_alu_valid & ~full & ~i_lsu_valid;

    assign push_rd   = i_lsu_valid ? i_lsu_rd   : i_alu_rd;
    assign push_data = i_lsu_valid ? i_lsu_data : i_alu_data;

    // x0 results complete the handshake but are dropped here.
    assign push = (lsu_acc | alu_acc) & (push_rd != 5'd0);
    assign pop  = ~empty & ~i_wb_hold;

    assign o_write_en = pop;
    assign o_rd_addr  = empty ? 5'd0 : rd_q[rptr_q];
    assign o_rd_data  = empty ? '0   : data_q[rptr_q];
    assign o_full     = full;
    assign o_busy     = busy_q;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (i_issue_valid && i_issue_rd != 5'd0) begin
            busy_set = 32'd1 << i_issue_rd;
        end
        if (pop) begin
            busy_clr = 32'd1 << o_rd_addr;
        end
        // Applying the set after the clear makes a same-edge set win.
        busy_nxt = ((busy_q & ~busy_clr) | busy_set) & ~32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            busy_q  <= busy_nxt;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            rd_q[wptr_q]   <= push_rd;
            data_q[wptr_q] <= push_data;
        end
    end

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the last match seen is the youngest.
    always_comb begin
        o_fwd1_hit  = 1'b0;
        o_fwd1_data = '0;
        o_fwd2_hit  = 1'b0;
        o_fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if (i_rs1_addr != 5'd0 &&
                    rd_q[rptr_q + AW'(i)] == i_rs1_addr) begin
                    o_fwd1_hit  = 1'b1;
                    o_fwd1_data = data_q[rptr_q + AW'(i)];
                end
                if (i_rs2_addr != 5'd0 &&
                    rd_q[rptr_q + AW'(i)] == i_rs2_addr) begin
                    o_fwd2_hit  = 1'b1;
                    o_fwd2_data = data_q[rptr_q + AW'(i)];
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd  = ^{i_rs1_addr, i_rs2_addr};
    assign o_fwd1_hit  = 1'b0;
    assign o_fwd1_data = '0;
    assign o_fwd2_hit  = 1'b0;
    assign o_fwd2_data = '0;
`endif

    // A second issue to a pending rd is illegal unless it is retiring now.
    issue_unique: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (i_issue_valid && i_issue_rd != 5'd0) |->
        (!busy_q[i_issue_rd] || (pop && o_rd_addr == i_issue_rd))
    );

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: table of per-cycle vectors plus
// hand-written sequences for reset-with-data and forwarding.
module tb_wb_commit;

    logic        clk;
    logic        rst_n;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        alu_rdy;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_d;
    logic        lsu_rdy;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        hold;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        we;
    logic [31:0] busy;
    logic        full;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        f1_hit;
    logic [31:0] f1_data;
    logic        f2_hit;
    logic [31:0] f2_data;

    int tests = 0;
    int fails = 0;

    wb_commit #(.DEPTH(4), .XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_alu_valid(alu_v), .i_alu_rd(alu_rd),
        .i_alu_data(alu_d), .o_alu_ready(alu_rdy),
        .i_lsu_valid(lsu_v), .i_lsu_rd(lsu_rd),
        .i_lsu_data(lsu_d), .o_lsu_ready(lsu_rdy),
        .i_issue_valid(iss_v), .i_issue_rd(iss_rd),
        .i_wb_hold(hold),
        .o_rd_addr(rd_addr), .o_rd_data(rd_data),
        .o_write_en(we), .o_busy(busy), .o_full(full),
        .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_fwd1_hit(f1_hit), .o_fwd1_data(f1_data),
        .o_fwd2_hit(f2_hit), .o_fwd2_data(f2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ird;
        logic        h;
        logic        e_ardy;
        logic        e_lrdy;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_full;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
        input logic iv, input logic [4:0] ird, input logic h,
        input logic ea, input logic el, input logic ew,
        input logic [4:0] eaddr, input logic [31:0] edata,
        input logic ef, input logic [31:0] eb);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.iv = iv; v.ird = ird; v.h = h;
        v.e_ardy = ea; v.e_lrdy = el; v.e_we = ew;
        v.e_addr = eaddr; v.e_data = edata;
        v.e_full = ef; v.e_busy = eb;
        vq.push_back(v);
    endtask

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_v = 0; alu_rd = 0; alu_d = 0;
        lsu_v = 0; lsu_rd = 0; lsu_d = 0;
        iss_v = 0; iss_rd = 0; hold = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string nm, input logic ew,
                              input logic [4:0] ea,
                              input logic [31:0] ed);
        check({nm, ".we"}, {31'd0, we}, {31'd0, ew});
        check({nm, ".addr"}, {27'd0, rd_addr}, {27'd0, ea});
        check({nm, ".data"}, rd_data, ed);
    endtask

    initial begin
        idle_inputs();
        rst_n = 0; rs1 = 0; rs2 = 0;

        // Reset overrides a same-cycle push and issue.
        alu_v = 1; alu_rd = 5'd6; alu_d = 32'h66;
        iss_v = 1; iss_rd = 5'd6;
        step();
        step();
        idle_inputs();
        rst_n = 1;
        #1;
        check_port("reset", 0, 0, 0);
        check("reset.busy", busy, 0);
        check("reset.full", {31'd0, full}, 0);
        check("reset.lsu_rdy", {31'd0, lsu_rdy}, 1);

        // Single ALU result, then LSU-vs-ALU priority.
        add(1,5,32'hDEADBEEF, 0,0,0, 0,0,0, 1,1,0,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,1,5,32'hDEADBEEF,0,0);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,0,0,0,0,0);
        add(1,4,32'h22, 1,3,32'h11, 0,0,0, 0,1,0,0,0,0,0);
        add(1,4,32'h22, 0,0,0, 0,0,0, 1,1,1,3,32'h11,0,0);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,1,4,32'h22,0,0);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,0,0,0,0,0);
        // Fill under hold, refused push while full, drain in order.
        add(1,1,32'h101, 0,0,0, 0,0,1, 1,1,0,0,0,0,0);
        add(1,2,32'h102, 0,0,0, 0,0,1, 1,1,0,1,32'h101,0,0);
        add(0,0,0, 1,3,32'h103, 0,0,1, 0,1,0,1,32'h101,0,0);
        add(1,4,32'h104, 0,0,0, 0,0,1, 1,1,0,1,32'h101,0,0);
        add(1,5,32'h105, 0,0,0, 0,0,1, 0,0,0,1,32'h101,1,0);
        add(1,5,32'h105, 0,0,0, 0,0,0, 0,0,1,1,32'h101,1,0);
        add(1,5,32'h105, 0,0,0, 0,0,0, 1,1,1,2,32'h102,0,0);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,1,3,32'h103,0,0);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,1,4,32'h104,0,0);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,1,5,32'h105,0,0);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,0,0,0,0,0);
        // Scoreboard: set, then set and clear on the same edge.
        add(0,0,0, 0,0,0, 1,7,0, 1,1,0,0,0,0,0);
        add(1,7,32'h77, 0,0,0, 0,0,0, 1,1,0,0,0,0,32'h80);
        add(0,0,0, 0,0,0, 1,7,0, 1,1,1,7,32'h77,0,32'h80);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,0,0,0,0,32'h80);
        add(1,7,32'h78, 0,0,0, 0,0,0, 1,1,0,0,0,0,32'h80);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,1,7,32'h78,0,32'h80);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,0,0,0,0,0);
        // x0 result and issue are handshaken but have no effect.
        add(1,0,32'hFF, 0,0,0, 1,0,0, 1,1,0,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0,0, 1,1,0,0,0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            string n;
            n = $sformatf("v%0d", i);
            alu_v = vq[i].av; alu_rd = vq[i].ard; alu_d = vq[i].ad;
            lsu_v = vq[i].lv; lsu_rd = vq[i].lrd; lsu_d = vq[i].ld;
            iss_v = vq[i].iv; iss_rd = vq[i].ird; hold = vq[i].h;
            #1;
            check({n, ".alu_rdy"}, {31'd0, alu_rdy}, {31'd0, vq[i].e_ardy});
            check({n, ".lsu_rdy"}, {31'd0, lsu_rdy}, {31'd0, vq[i].e_lrdy});
            check_port(n, vq[i].e_we, vq[i].e_addr, vq[i].e_data);
            check({n, ".full"}, {31'd0, full}, {31'd0, vq[i].e_full});
            check({n, ".busy"}, busy, vq[i].e_busy);
            step();
        end

        // Reset with three buffered entries and three pending bits.
        idle_inputs();
        for (int r = 10; r < 13; r++) begin
            iss_v = 1; iss_rd = 5'(r);
            step();
        end
        idle_inputs();
        hold = 1;
        for (int r = 10; r < 13; r++) begin
            alu_v = 1; alu_rd = 5'(r); alu_d = 32'(r * 16);
            step();
        end
        idle_inputs();
        hold = 1;
        #1;
        check("pre_rst.busy", busy, 32'h1C00);
        check_port("pre_rst", 0, 10, 32'hA0);
        hold = 0;
        rst_n = 0;
        alu_v = 1; alu_rd = 5'd13; alu_d = 32'hD;
        iss_v = 1; iss_rd = 5'd13;
        step();
        idle_inputs();
        rst_n = 1;
        #1;
        check_port("post_rst", 0, 0, 0);
        check("post_rst.busy", busy, 0);
        check("post_rst.full", {31'd0, full}, 0);
        step();
        check_port("post_rst2", 0, 0, 0);

        // Forwarding: youngest of two rd=9 entries wins.
        hold = 1;
        alu_v = 1; alu_rd = 5'd9; alu_d = 32'hA;
        step();
        alu_d = 32'hB;
        #1;
        check("fwd.no_bypass", {31'd0, f2_hit}, 0);
        step();
        idle_inputs();
        hold = 1;
        rs1 = 5'd9; rs2 = 5'd9;
        #1;
`ifdef WB_FWD_EN
        check("fwd1.hit", {31'd0, f1_hit}, 1);
        check("fwd1.data", f1_data, 32'hB);
        check("fwd2.hit", {31'd0, f2_hit}, 1);
        check("fwd2.data", f2_data, 32'hB);
`else
        check("fwd1.hit", {31'd0, f1_hit}, 0);
        check("fwd1.data", f1_data, 0);
        check("fwd2.hit", {31'd0, f2_hit}, 0);
        check("fwd2.data", f2_data, 0);
`endif
        rs1 = 5'd0; rs2 = 5'd8;
        #1;
        check("fwd1.x0", {31'd0, f1_hit}, 0);
        check("fwd2.miss", {31'd0, f2_hit}, 0);
        check("fwd2.miss_data", f2_data, 0);
        hold = 0;
        #1;
        check_port("fwd_drain0", 1, 9, 32'hA);
        step();
        check_port("fwd_drain1", 1, 9, 32'hB);
        step();
        check_port("fwd_drain2", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
